// File: rtl/mac_cfg_loader_pkg.sv
// Shared widths and loader state encoding for the mac_cluster serial cfg loader.
package mac_cfg_loader_pkg;

  localparam int MAC_ACC_WIDTH  = 8;
  localparam int MAC_CONF_WIDTH = 4;
  localparam int MAC_CFG_WIDTH  = 4 * MAC_ACC_WIDTH + MAC_CONF_WIDTH;

  typedef enum logic [1:0] {
    MAC_LD_UNCFG  = 2'd0,
    MAC_LD_SHIFT  = 2'd1,
    MAC_LD_COMMIT = 2'd2,
    MAC_LD_ACTIVE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/mac_cfg_loader_if.sv
// Loader-side bundle: serial cfg stream and run request in, cluster controls out.
interface mac_cfg_loader_if
  import mac_cfg_loader_pkg::*;
#(
  parameter int CFG_W = MAC_CFG_WIDTH
);
  logic             load_start;
  logic             cfg_valid;
  logic             cfg_in;
  logic             run;
  logic [CFG_W-1:0] cfg;
  logic             mac_rst;
  logic             mac_en;
  logic             cfg_busy;
  logic             cfg_done;
  logic             configured;

  modport master (
    output load_start, cfg_valid, cfg_in, run,
    input  cfg, mac_rst, mac_en, cfg_busy, cfg_done, configured
  );

  modport slave (
    input  load_start, cfg_valid, cfg_in, run,
    output cfg, mac_rst, mac_en, cfg_busy, cfg_done, configured
  );
endinterface

// File: rtl/mac_cfg_loader.sv
// Shifts a cfg word in LSB-first, commits it atomically, and sequences the cluster's rst/en.
module mac_cfg_loader
  import mac_cfg_loader_pkg::*;
#(
  parameter int ACC_WIDTH  = MAC_ACC_WIDTH,
  parameter int CONF_WIDTH = MAC_CONF_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  mac_cfg_loader_if.slave   bus
);
  localparam int CFG_W = 4 * ACC_WIDTH + CONF_WIDTH;
  localparam int CNT_W = $clog2(CFG_W + 1);

  ld_state_e        state_q, state_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             configured_q, configured_d;
  logic             rst2_q, rst2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MAC_LD_UNCFG;
      shadow_q     <= '0;
      cfg_q        <= '0;
      count_q      <= '0;
      configured_q <= 1'b0;
      rst2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      cfg_q        <= cfg_d;
      count_q      <= count_d;
      configured_q <= configured_d;
      rst2_q       <= rst2_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    cfg_d        = cfg_q;
    count_d      = count_q;
    configured_d = configured_q;
    rst2_d       = 1'b0;
    case (state_q)
      MAC_LD_UNCFG: begin
        if (bus.load_start) begin
          state_d = MAC_LD_SHIFT;
          count_d = '0;
        end
      end
      MAC_LD_SHIFT: begin
        // A restart outranks a bit arriving in the same cycle; that bit is dropped.
        if (bus.load_start) begin
          count_d = '0;
        end else if (bus.cfg_valid) begin
          shadow_d = {bus.cfg_in, shadow_q[CFG_W-1:1]};
          if (count_q == CNT_W'(CFG_W - 1)) begin
            count_d = '0;
            state_d = MAC_LD_COMMIT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      MAC_LD_COMMIT: begin
        cfg_d        = shadow_q;
        configured_d = 1'b1;
        count_d      = '0;
        rst2_d       = 1'b1;
        state_d      = bus.load_start ? MAC_LD_SHIFT : MAC_LD_ACTIVE;
      end
      MAC_LD_ACTIVE: begin
        if (bus.load_start) begin
          state_d = MAC_LD_SHIFT;
        end
      end
      default: state_d = MAC_LD_UNCFG;
    endcase
  end

  logic mac_rst_c, mac_en_c, busy_c, done_c;

  // The second rst cycle lets the cluster reload from the freshly registered cfg.
  always_comb begin
    mac_rst_c = 1'b1;
    mac_en_c  = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    if (!rst) begin
      case (state_q)
        MAC_LD_SHIFT: begin
          mac_rst_c = ~configured_q;
          busy_c    = 1'b1;
        end
        MAC_LD_COMMIT: begin
          busy_c = 1'b1;
          done_c = 1'b1;
        end
        MAC_LD_ACTIVE: begin
          mac_rst_c = rst2_q;
          mac_en_c  = bus.run & ~rst2_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg        = cfg_q;
  assign bus.mac_rst    = mac_rst_c;
  assign bus.mac_en     = mac_en_c;
  assign bus.cfg_busy   = busy_c;
  assign bus.cfg_done   = done_c;
  assign bus.configured = configured_q;

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Directed bench for mac_cfg_loader with ACC_WIDTH=8, CONF_WIDTH=4 (36-bit cfg word).
module tb_mac_cfg_loader;
  import mac_cfg_loader_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mac_cfg_loader_if bus_if ();

  mac_cfg_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks for every cycle spent in SHIFT.
  task automatic chk_shift(input string tag, input logic [35:0] old_cfg, input logic shift_rst);
    chk({tag, " busy"}, 36'(bus_if.cfg_busy), 36'd1);
    chk({tag, " en"}, 36'(bus_if.mac_en), 36'd0);
    chk({tag, " rst"}, 36'(bus_if.mac_rst), 36'(shift_rst));
    chk({tag, " done"}, 36'(bus_if.cfg_done), 36'd0);
    chk({tag, " cfg"}, bus_if.cfg, old_cfg);
  endtask

  // load_start (with a colliding valid bit that must be discarded), then nbits bits LSB-first.
  task automatic frame(input string tag, input logic [35:0] w, input int nbits, input bit gap,
                       input logic [35:0] old_cfg, input logic shift_rst);
    bus_if.load_start = 1'b1;
    bus_if.cfg_valid  = 1'b1;
    bus_if.cfg_in     = 1'b1;
    tick();
    bus_if.load_start = 1'b0;
    bus_if.cfg_valid  = 1'b0;
    chk_shift({tag, " start"}, old_cfg, shift_rst);
    for (int i = 0; i < nbits; i++) begin
      if (gap) begin
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_in    = ~w[i];
        tick();
        chk_shift({tag, " gap"}, old_cfg, shift_rst);
      end
      bus_if.cfg_valid = 1'b1;
      bus_if.cfg_in    = w[i];
      tick();
      if (i == 35) begin
        chk({tag, " commit done"}, 36'(bus_if.cfg_done), 36'd1);
        chk({tag, " commit rst"}, 36'(bus_if.mac_rst), 36'd1);
        chk({tag, " commit en"}, 36'(bus_if.mac_en), 36'd0);
        chk({tag, " commit busy"}, 36'(bus_if.cfg_busy), 36'd1);
        chk({tag, " commit cfg"}, bus_if.cfg, old_cfg);
      end else begin
        chk_shift({tag, " bit"}, old_cfg, shift_rst);
      end
    end
    bus_if.cfg_valid = 1'b0;
    bus_if.cfg_in    = 1'b0;
  endtask

  // The two cycles after COMMIT: rst still high with new cfg, then en follows run.
  task automatic after_commit(input string tag, input logic [35:0] exp_cfg);
    tick();
    chk({tag, " act1 cfg"}, bus_if.cfg, exp_cfg);
    chk({tag, " act1 rst"}, 36'(bus_if.mac_rst), 36'd1);
    chk({tag, " act1 en"}, 36'(bus_if.mac_en), 36'd0);
    chk({tag, " act1 done"}, 36'(bus_if.cfg_done), 36'd0);
    chk({tag, " act1 busy"}, 36'(bus_if.cfg_busy), 36'd0);
    chk({tag, " act1 configured"}, 36'(bus_if.configured), 36'd1);
    tick();
    chk({tag, " act2 rst"}, 36'(bus_if.mac_rst), 36'd0);
    chk({tag, " act2 en"}, 36'(bus_if.mac_en), 36'(bus_if.run));
    chk({tag, " act2 done"}, 36'(bus_if.cfg_done), 36'd0);
  endtask

  initial begin
    vectors              = 0;
    miscompares          = 0;
    rst                  = 1'b1;
    bus_if.load_start    = 1'b0;
    bus_if.cfg_valid     = 1'b0;
    bus_if.cfg_in        = 1'b0;
    bus_if.run           = 1'b0;

    // 1. reset and idle
    tick();
    tick();
    chk("rst mac_rst", 36'(bus_if.mac_rst), 36'd1);
    chk("rst mac_en", 36'(bus_if.mac_en), 36'd0);
    chk("rst busy", 36'(bus_if.cfg_busy), 36'd0);
    chk("rst cfg", bus_if.cfg, 36'd0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle cfg", bus_if.cfg, 36'd0);
      chk("idle mac_rst", 36'(bus_if.mac_rst), 36'd1);
      chk("idle mac_en", 36'(bus_if.mac_en), 36'd0);
      chk("idle configured", 36'(bus_if.configured), 36'd0);
      chk("idle done", 36'(bus_if.cfg_done), 36'd0);
    end

    // 2. first frame with run held high
    bus_if.run = 1'b1;
    frame("t2", 36'h9_1234_5678, 36, 1'b0, 36'd0, 1'b1);
    after_commit("t2", 36'h9_1234_5678);
    chk("t2 en run1", 36'(bus_if.mac_en), 36'd1);
    bus_if.run = 1'b0;
    #1;
    chk("t2 en run0", 36'(bus_if.mac_en), 36'd0);
    bus_if.run = 1'b1;
    #1;

    // 3. abort after 20 bits, then a clean frame
    frame("t3 abort", 36'hF_FFFF_FFFF, 20, 1'b0, 36'h9_1234_5678, 1'b0);
    frame("t3", 36'h0_0000_00A5, 36, 1'b0, 36'h9_1234_5678, 1'b0);
    after_commit("t3", 36'h0_0000_00A5);

    // 4. gapped stream
    frame("t4", 36'hA_AAAA_AAAA, 36, 1'b1, 36'h0_0000_00A5, 1'b0);
    after_commit("t4", 36'hA_AAAA_AAAA);

    // 5. reconfigure while running
    chk("t5 en before", 36'(bus_if.mac_en), 36'd1);
    frame("t5", 36'h1_0000_0003, 36, 1'b0, 36'hA_AAAA_AAAA, 1'b0);
    after_commit("t5", 36'h1_0000_0003);

    // 6. reset mid-frame, then stray valid bits
    frame("t6", 36'h1_2345_6789, 17, 1'b0, 36'h1_0000_0003, 1'b0);
    rst = 1'b1;
    tick();
    chk("t6 rst mac_rst", 36'(bus_if.mac_rst), 36'd1);
    chk("t6 rst busy", 36'(bus_if.cfg_busy), 36'd0);
    chk("t6 rst cfg", bus_if.cfg, 36'd0);
    chk("t6 rst configured", 36'(bus_if.configured), 36'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus_if.cfg_valid = c[0];
      bus_if.cfg_in    = 1'b1;
      tick();
      chk("t6 stray busy", 36'(bus_if.cfg_busy), 36'd0);
      chk("t6 stray cfg", bus_if.cfg, 36'd0);
      chk("t6 stray mac_rst", 36'(bus_if.mac_rst), 36'd1);
      chk("t6 stray en", 36'(bus_if.mac_en), 36'd0);
    end
    bus_if.cfg_valid = 1'b0;

    // load_start during COMMIT goes straight back to SHIFT
    frame("t7", 36'h0_0000_0005, 36, 1'b0, 36'd0, 1'b1);
    bus_if.load_start = 1'b1;
    tick();
    bus_if.load_start = 1'b0;
    chk("t7 busy", 36'(bus_if.cfg_busy), 36'd1);
    chk("t7 cfg", bus_if.cfg, 36'h0_0000_0005);
    chk("t7 configured", 36'(bus_if.configured), 36'd1);
    chk("t7 mac_rst", 36'(bus_if.mac_rst), 36'd0);
    chk("t7 done", 36'(bus_if.cfg_done), 36'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
